md_sequencer: RTL and testbench

Multiply/divide sequencer for the five-stage pipeline. It accepts MD instructions from the E stage and owns the HI/LO registers. It models the fixed multi-cycle latency of mult/div with a busy FSM, and raises the stall request the hazard unit uses to hold any MD instruction in D. Its read-out (`E_MDData`) travels with the instruction into the E/M pipeline register.

---
 rtl/md_pkg.sv | 21 ++
 rtl/md_sequencer_if.sv | 27 ++
 rtl/md_compute.sv | 74 +++++++
 rtl/md_sequencer.sv | 100 ++++++++++
 tb/tb_md_sequencer.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide sequencer.
//   md_op_e        : MD operation encoding carried by the E-stage instruction
//   *_CYCLES_DEF   : default busy-period lengths for mult and div
package md_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } md_op_e;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/md_sequencer_if.sv
// Pipeline <-> MD sequencer bundle.
//   master : pipeline side, drives the E-stage op/operands and D-stage MD flag
//   slave  : sequencer side, returns read data, busy, start and stall request
interface md_sequencer_if;
  import md_pkg::*;

  md_op_e      E_MDOp;
  logic        E_Valid;
  logic [31:0] E_A;
  logic [31:0] E_B;
  logic        D_IsMD;
  logic [31:0] E_MDData;
  logic        MD_Busy;
  logic        MD_Start;
  logic        Stall_MD;

  modport master (
    output E_MDOp, E_Valid, E_A, E_B, D_IsMD,
    input  E_MDData, MD_Busy, MD_Start, Stall_MD
  );

  modport slave (
    input  E_MDOp, E_Valid, E_A, E_B, D_IsMD,
    output E_MDData, MD_Busy, MD_Start, Stall_MD
  );

endinterface

// File: rtl/md_compute.sv
// Combinational mult/div datapath.
//   op_i     : MD operation
//   a_i, b_i : rs / rt operands
//   hi_o     : product[63:32] or remainder
//   lo_o     : product[31:0]  or quotient
//   wr_en_o  : 0 when a divide has a zero divisor (HI/LO must stay unchanged)
module md_compute
  import md_pkg::*;
(
  input  md_op_e      op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        wr_en_o
);

  logic [63:0] a_sx, b_sx, a_zx, b_zx;
  logic [63:0] prod_s, prod_u;
  logic        div_zero, div_ovf;
  logic [31:0] b_sdiv, b_udiv;
  logic [31:0] q_s, r_s, q_u, r_u;

  // Low 64 bits of a product of sign-extended operands equal the signed product.
  assign a_sx   = {{32{a_i[31]}}, a_i};
  assign b_sx   = {{32{b_i[31]}}, b_i};
  assign a_zx   = {32'b0, a_i};
  assign b_zx   = {32'b0, b_i};
  assign prod_s = a_sx * b_sx;
  assign prod_u = a_zx * b_zx;

  assign div_zero = (b_i == 32'd0);
  assign div_ovf  = (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF);

  // Divisors are steered away from 0 and from the INT_MIN / -1 overflow case so
  // the dividers never see an undefined operation; those cases are overridden below.
  assign b_sdiv = (div_zero || div_ovf) ? 32'd1 : b_i;
  assign b_udiv = div_zero ? 32'd1 : b_i;
  assign q_s    = $signed(a_i) / $signed(b_sdiv);
  assign r_s    = $signed(a_i) % $signed(b_sdiv);
  assign q_u    = a_i / b_udiv;
  assign r_u    = a_i % b_udiv;

  always_comb begin
    hi_o    = '0;
    lo_o    = '0;
    wr_en_o = 1'b1;
    case (op_i)
      MD_MULT:  {hi_o, lo_o} = prod_s;
      MD_MULTU: {hi_o, lo_o} = prod_u;
      MD_DIV: begin
        if (div_zero) begin
          wr_en_o = 1'b0;
        end else if (div_ovf) begin
          lo_o = 32'h8000_0000;
          hi_o = 32'd0;
        end else begin
          lo_o = q_s;
          hi_o = r_s;
        end
      end
      MD_DIVU: begin
        if (div_zero) begin
          wr_en_o = 1'b0;
        end else begin
          lo_o = q_u;
          hi_o = r_u;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_sequencer.sv
// Multiply/divide sequencer: owns HI/LO, models fixed mult/div latency with an
// IDLE/BUSY FSM and raises the D-stage stall for MD instructions.
//   clk, reset : clock, synchronous active-high reset
//   md         : slave side of md_sequencer_if (E-stage op/operands, D_IsMD in;
//                E_MDData, MD_Busy, MD_Start, Stall_MD out)
module md_sequencer
  import md_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input logic           clk,
  input logic           reset,
  md_sequencer_if.slave md
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  localparam logic [3:0] MultLoad = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DivLoad  = 4'(DIV_CYCLES - 1);

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] hi_q, lo_q;
  logic [31:0] pend_hi_q, pend_lo_q;
  logic        pend_we_q;

  logic        is_muldiv, is_div, md_start;
  logic [31:0] res_hi, res_lo;
  logic        res_we;

  assign is_muldiv = md.E_MDOp inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
  assign is_div    = md.E_MDOp inside {MD_DIV, MD_DIVU};
  assign md_start  = md.E_Valid && is_muldiv && (state_q == StIdle);

  md_compute u_compute (
    .op_i    (md.E_MDOp),
    .a_i     (md.E_A),
    .b_i     (md.E_B),
    .hi_o    (res_hi),
    .lo_o    (res_lo),
    .wr_en_o (res_we)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_we_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (md_start) begin
            pend_hi_q <= res_hi;
            pend_lo_q <= res_lo;
            pend_we_q <= res_we;
            cnt_q     <= is_div ? DivLoad : MultLoad;
            state_q   <= StBusy;
          end else if (md.E_Valid && md.E_MDOp == MD_MTHI) begin
            hi_q <= md.E_A;
          end else if (md.E_Valid && md.E_MDOp == MD_MTLO) begin
            lo_q <= md.E_A;
          end
        end
        StBusy: begin
          // Any MD op seen in E while busy is ignored.
          if (cnt_q == 4'd0) begin
            if (pend_we_q) begin
              hi_q <= pend_hi_q;
              lo_q <= pend_lo_q;
            end
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    md.E_MDData = '0;
    if (md.E_MDOp == MD_MFHI) begin
      md.E_MDData = hi_q;
    end else if (md.E_MDOp == MD_MFLO) begin
      md.E_MDData = lo_q;
    end
  end

  assign md.MD_Busy  = (state_q == StBusy);
  assign md.MD_Start = md_start;
  // Start cycle is included: the D instruction would otherwise reach E while busy.
  assign md.Stall_MD = md.D_IsMD && (md_start || (state_q == StBusy));

endmodule

// File: tb/tb_md_sequencer.sv
module tb_md_sequencer;
  import md_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  md_sequencer_if bus ();

  md_sequencer #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .md    (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference architectural state.
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.E_Valid = 1'b0;
    bus.E_MDOp  = MD_NONE;
    bus.E_A     = 32'd0;
    bus.E_B     = 32'd0;
  endtask

  // Architectural effect of a completed mult/div, from plain 64-bit arithmetic.
  task automatic model_apply(input md_op_e op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      MD_MULT: begin
        q = sa * sb;
        m_hi = q[63:32];
        m_lo = q[31:0];
      end
      MD_MULTU: begin
        up = {32'd0, a} * {32'd0, b};
        m_hi = up[63:32];
        m_lo = up[31:0];
      end
      MD_DIV: if (b != 0) begin
        q = sa / sb;
        r = sa % sb;
        m_lo = q[31:0];
        m_hi = r[31:0];
      end
      MD_DIVU: if (b != 0) begin
        m_lo = a / b;
        m_hi = a % b;
      end
      default: ;
    endcase
  endtask

  task automatic read_hilo(input string tag);
    bus.E_Valid = 1'b1;
    bus.E_MDOp  = MD_MFHI;
    #1 chk({tag, ".mfhi"}, bus.E_MDData, m_hi);
    bus.E_MDOp  = MD_MFLO;
    #1 chk({tag, ".mflo"}, bus.E_MDData, m_lo);
    idle_inputs();
  endtask

  task automatic mt(input md_op_e op, input logic [31:0] a);
    bus.E_Valid = 1'b1;
    bus.E_MDOp  = op;
    bus.E_A     = a;
    step();
    if (op == MD_MTHI) m_hi = a;
    else m_lo = a;
    idle_inputs();
  endtask

  // Issue a mult/div, count busy cycles, check stall throughout, then read back.
  task automatic run_md(input string tag, input md_op_e op, input logic [31:0] a,
                        input logic [31:0] b, input logic d_ismd, input logic poke);
    int exp_n, busy_n;
    exp_n = (op == MD_MULT || op == MD_MULTU) ? 5 : 10;
    bus.D_IsMD  = d_ismd;
    bus.E_Valid = 1'b1;
    bus.E_MDOp  = op;
    bus.E_A     = a;
    bus.E_B     = b;
    #1;
    chk({tag, ".start"}, 32'(bus.MD_Start), 32'd1);
    chk({tag, ".stall0"}, 32'(bus.Stall_MD), 32'(d_ismd));
    step();
    idle_inputs();
    busy_n = 0;
    while (bus.MD_Busy === 1'b1 && busy_n < 40) begin
      if (busy_n == 0) chk({tag, ".stallb"}, 32'(bus.Stall_MD), 32'(d_ismd));
      if (poke && busy_n == 1) begin
        // An MD op reaching E while busy must be ignored.
        bus.E_Valid = 1'b1;
        bus.E_MDOp  = MD_MTHI;
        bus.E_A     = 32'hDEAD_BEEF;
        #1 chk({tag, ".nostart"}, 32'(bus.MD_Start), 32'd0);
      end
      if (poke && busy_n == 2) begin
        bus.E_MDOp = MD_MULT;
        bus.E_A    = 32'd7;
        bus.E_B    = 32'd9;
        #1 chk({tag, ".nostart2"}, 32'(bus.MD_Start), 32'd0);
      end
      busy_n++;
      step();
      idle_inputs();
    end
    chk({tag, ".busy_n"}, 32'(busy_n), 32'(exp_n));
    chk({tag, ".stall_after"}, 32'(bus.Stall_MD), 32'd0);
    bus.D_IsMD = 1'b0;
    model_apply(op, a, b);
    read_hilo(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    bus.D_IsMD = 1'b0;
    idle_inputs();
    step();
    step();
    chk("rst.busy", 32'(bus.MD_Busy), 32'd0);
    chk("rst.start", 32'(bus.MD_Start), 32'd0);
    chk("rst.stall", 32'(bus.Stall_MD), 32'd0);
    chk("rst.data", bus.E_MDData, 32'd0);
    reset = 1'b0;
    step();
    read_hilo("rst");

    // Directed cases.
    run_md("mult", MD_MULT, 32'd5, 32'hFFFF_FFFD, 1'b1, 1'b1);
    chk("mult.hi", m_hi, 32'hFFFF_FFFF);
    chk("mult.lo", m_lo, 32'hFFFF_FFF1);
    run_md("div", MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    run_md("divu", MD_DIVU, 32'd7, 32'd2, 1'b1, 1'b0);
    run_md("divovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    mt(MD_MTHI, 32'h0000_1234);
    read_hilo("mthi");
    mt(MD_MTLO, 32'h0000_5678);
    read_hilo("mtlo");
    run_md("div0", MD_DIV, 32'd100, 32'd0, 1'b0, 1'b1);
    run_md("divu0", MD_DIVU, 32'd100, 32'd0, 1'b0, 1'b0);

    // Invalid E-stage op must not write.
    bus.E_Valid = 1'b0;
    bus.E_MDOp  = MD_MTLO;
    bus.E_A     = 32'hCAFE_F00D;
    step();
    bus.E_MDOp = MD_MULT;
    #1 chk("inval.start", 32'(bus.MD_Start), 32'd0);
    idle_inputs();
    read_hilo("inval");

    // Stall stays low with no MD op in D.
    bus.D_IsMD = 1'b0;
    bus.E_Valid = 1'b1;
    bus.E_MDOp  = MD_MULTU;
    bus.E_A     = 32'hFFFF_FFFF;
    bus.E_B     = 32'hFFFF_FFFF;
    #1 chk("nostall.start", 32'(bus.Stall_MD), 32'd0);
    step();
    idle_inputs();
    for (int i = 0; i < 5; i++) begin
      chk("nostall.busy", 32'(bus.Stall_MD), 32'd0);
      step();
    end
    model_apply(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    read_hilo("multu");

    // Reset during the third busy cycle of a DIV.
    bus.E_Valid = 1'b1;
    bus.E_MDOp  = MD_DIV;
    bus.E_A     = 32'd1000;
    bus.E_B     = 32'd3;
    step();
    idle_inputs();
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    chk("rstmid.busy", 32'(bus.MD_Busy), 32'd0);
    read_hilo("rstmid");
    run_md("post_rst", MD_MULT, 32'd2, 32'd3, 1'b0, 1'b0);
    chk("post_rst.lo", m_lo, 32'd6);

    // Randomized mult/div against the reference model.
    for (int i = 0; i < 16; i++) begin
      md_op_e      op;
      logic [31:0] a, b;
      op = md_op_e'(4'($urandom_range(1, 4)));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 5) == 0) b = 32'd0;
      if ($urandom_range(0, 5) == 0) b = $urandom_range(1, 9);
      run_md("rand", op, a, b, 1'($urandom_range(0, 1)), 1'b0);
      if ($urandom_range(0, 2) == 0) begin
        mt(MD_MTLO, $urandom);
        read_hilo("rand_mt");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
